// File: rtl/cube_root_seq.sv
// Sequential cube root: y = floor(cbrt(number*1e6)), one root bit per clock, then BCD d2.d1d0.
// Optional CBRT_EXACT_EN adds the exact output (remainder == 0).
module cube_root_seq #(
  parameter bit DONE_STICKY = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] number,
  output logic       busy,
  output logic       done,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0
`ifdef CBRT_EXACT_EN
  ,
  output logic       exact
`endif
);

  typedef enum logic [1:0] {IDLE, CALC, BCD} state_t;

  state_t      state, state_nxt;
  logic [31:0] x;
  logic [9:0]  y;
  logic [4:0]  s;
  logic [3:0]  cnt;
  logic [11:0] bcd;

  logic [35:0] y2, b;
  logic        take;
  logic [11:0] bcd_adj;
  logic        accept, shift, commit;

  // Trial subtrahend (3*y2*(y2+1)+1) << s in full 36-bit width.
  always_comb begin
    y2   = {25'd0, y, 1'b0};
    b    = (36'd3 * y2 * (y2 + 36'd1) + 36'd1) << s;
    take = ({4'd0, x} >= b);
    for (int i = 0; i < 3; i++)
      bcd_adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (s == 5'd0) state_nxt = BCD;
      BCD:     if (cnt == 4'd10) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept = (state == IDLE) && start;
    shift  = (state == BCD) && (cnt != 4'd10);
    commit = (state == BCD) && (cnt == 4'd10);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x    <= '0;
      y    <= '0;
      s    <= '0;
      cnt  <= '0;
      bcd  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      d2   <= '0;
      d1   <= '0;
      d0   <= '0;
`ifdef CBRT_EXACT_EN
      exact <= 1'b0;
`endif
    end else begin
      if (accept) begin
        x    <= 32'(number) * 32'd1_000_000;
        y    <= '0;
        s    <= 5'd30;
        cnt  <= '0;
        bcd  <= '0;
        busy <= 1'b1;
        done <= 1'b0;
      end else if (state == IDLE && !DONE_STICKY) begin
        done <= 1'b0;
      end

      if (state == CALC) begin
        if (take) x <= x - b[31:0];
        y <= {y[8:0], take};
        if (s != 5'd0) s <= s - 5'd3;
      end

      // Double-dabble shifts the root out of y into bcd; y is not needed afterwards.
      if (shift) begin
        {bcd, y} <= {bcd_adj[10:0], y, 1'b0};
        cnt      <= cnt + 4'd1;
      end

      if (commit) begin
        d2   <= bcd[11:8];
        d1   <= bcd[7:4];
        d0   <= bcd[3:0];
        done <= 1'b1;
        busy <= 1'b0;
`ifdef CBRT_EXACT_EN
        exact <= (x == 32'd0);
`endif
      end
    end
  end

endmodule

// File: tb/tb_cube_root_seq.sv
// Directed and sweep bench for cube_root_seq; a pulse-done and a sticky-done instance share stimulus.
module tb_cube_root_seq;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] number;
  logic       busy, done, busy_s, done_s;
  logic [3:0] d2, d1, d0, s2, s1, s0;
`ifdef CBRT_EXACT_EN
  logic       exact, exact_s;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cube_root_seq #(.DONE_STICKY(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .number(number),
    .busy(busy), .done(done), .d2(d2), .d1(d1), .d0(d0)
`ifdef CBRT_EXACT_EN
    , .exact(exact)
`endif
  );

  cube_root_seq #(.DONE_STICKY(1'b1)) dut_s (
    .clk(clk), .rst(rst), .start(start), .number(number),
    .busy(busy_s), .done(done_s), .d2(s2), .d1(s1), .d0(s0)
`ifdef CBRT_EXACT_EN
    , .exact(exact_s)
`endif
  );

  typedef struct {
    logic [7:0] n;
    int         e2, e1, e0, ex;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int cbrt_ref(input int n);
    longint v = longint'(n) * 1000000;
    longint y = 0;
    while ((y + 1) * (y + 1) * (y + 1) <= v) y++;
    return int'(y);
  endfunction

  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run(input logic [7:0] n, output int lat, output int bcnt);
    @(negedge clk);
    number = n;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done(lat, bcnt);
  endtask

  initial begin
    vec_t tbl[7];
    int   lat, bcnt, seen, y;

    tbl[0] = '{8'd0,   0, 0, 0, 1};
    tbl[1] = '{8'd1,   1, 0, 0, 1};
    tbl[2] = '{8'd8,   2, 0, 0, 1};
    tbl[3] = '{8'd27,  3, 0, 0, 1};
    tbl[4] = '{8'd2,   1, 2, 5, 0};
    tbl[5] = '{8'd100, 4, 6, 4, 0};
    tbl[6] = '{8'd255, 6, 3, 4, 0};

    rst = 1'b1; start = 1'b0; number = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_digits", {d2, d1, d0}, 0);
`ifdef CBRT_EXACT_EN
    chk("reset_exact", exact, 0);
`endif
    rst = 1'b0;

    foreach (tbl[i]) begin
      run(tbl[i].n, lat, bcnt);
      chk($sformatf("lat_%0d", tbl[i].n), lat, 22);
      chk($sformatf("busy_cycles_%0d", tbl[i].n), bcnt, 22);
      chk($sformatf("d2_%0d", tbl[i].n), d2, tbl[i].e2);
      chk($sformatf("d1_%0d", tbl[i].n), d1, tbl[i].e1);
      chk($sformatf("d0_%0d", tbl[i].n), d0, tbl[i].e0);
`ifdef CBRT_EXACT_EN
      chk($sformatf("exact_%0d", tbl[i].n), exact, tbl[i].ex);
`endif
      @(negedge clk);
      chk($sformatf("pulse_end_%0d", tbl[i].n), done, 0);
      chk($sformatf("sticky_hold_%0d", tbl[i].n), done_s, 1);
    end

    // Sticky done survives idle cycles and drops on the accepting edge.
    repeat (5) @(negedge clk);
    chk("sticky_idle5", done_s, 1);
    chk("pulse_idle5", done, 0);
    number = 8'd1;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    chk("sticky_drop_on_start", done_s, 0);
    chk("sticky_busy_on_start", busy_s, 1);
    wait_done(lat, bcnt);
    chk("sticky_run_lat", lat, 22);
    chk("sticky_run_digits", {s2, s1, s0}, 12'h100);

    // start held through a run, operand changed mid-run.
    @(negedge clk);
    number = 8'd255;
    start  = 1'b1;
    @(negedge clk);
    number = 8'd8;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("held_lat", lat, 22);
    chk("held_digits", {d2, d1, d0}, 12'h634);
    @(negedge clk);
    start = 1'b0;
    chk("held_reaccept_busy", busy, 1);
    chk("held_reaccept_done", done, 0);
    wait_done(lat, bcnt);
    chk("held_second_lat", lat, 22);
    chk("held_second_digits", {d2, d1, d0}, 12'h200);

    // Reset mid-computation.
    @(negedge clk);
    number = 8'd27;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_digits", {d2, d1, d0}, 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("midrst_no_done", seen, 0);
    run(8'd8, lat, bcnt);
    chk("postrst_lat", lat, 22);
    chk("postrst_digits", {d2, d1, d0}, 12'h200);

    // Full operand sweep against the reference model.
    for (int n = 0; n < 256; n++) begin
      run(8'(n), lat, bcnt);
      y = cbrt_ref(n);
      chk($sformatf("sweep_lat_%0d", n), lat, 22);
      chk($sformatf("sweep_root_%0d", n), int'(d2) * 100 + int'(d1) * 10 + int'(d0), y);
      chk($sformatf("sweep_d1_%0d", n), d1, (y / 10) % 10);
`ifdef CBRT_EXACT_EN
      chk($sformatf("sweep_exact_%0d", n), exact,
          (longint'(y) * y * y == longint'(n) * 1000000) ? 1 : 0);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
